// File: rtl/bcd_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter.
package bcd_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StShift = 2'd1,
    StDone  = 2'd2
  } state_e;

  localparam int unsigned BCD_DIGIT_W = 4;
  localparam logic [3:0]  ADJ_THRESH  = 4'd5;
  localparam logic [3:0]  ADJ_ADD     = 4'd3;

  // Largest value representable in the given number of BCD digits.
  function automatic int unsigned bcd_max(input int unsigned digits);
    int unsigned p;
    p = 1;
    for (int unsigned i = 0; i < digits; i++) begin
      p = p * 10;
    end
    return p - 1;
  endfunction

endpackage

// File: rtl/bcd_digit_adjust.sv
// Double-dabble digit correction: add 3 to a BCD digit that is 5 or more.
module bcd_digit_adjust
  import bcd_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] digit_i,
  output logic [BCD_DIGIT_W-1:0] digit_o
);

  // Carry out of the digit is dropped; it cannot occur for a legal digit.
  assign digit_o = (digit_i >= ADJ_THRESH) ? (digit_i + ADJ_ADD) : digit_i;

endmodule

// File: rtl/bcd_convert_seq.sv
// Sequential shift-and-add-3 binary-to-BCD converter, one input bit per clock,
// with a START/BUSY/DONE handshake and an atomically updated BCD output.
module bcd_convert_seq
  import bcd_pkg::*;
#(
  parameter int unsigned BIN_W  = 10,
  parameter int unsigned DIGITS = 4
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic                          START,
  input  logic [BIN_W-1:0]              BIN,
  output logic                          BUSY,
  output logic                          DONE,
  output logic [BCD_DIGIT_W*DIGITS-1:0] BCDOUT,
  output logic                          OVF
);

  localparam int unsigned BcdW   = BCD_DIGIT_W * DIGITS;
  localparam int unsigned CntW   = $clog2(BIN_W);
  localparam int unsigned MaxVal = bcd_max(DIGITS);

  state_e            state_q;
  logic [BIN_W-1:0]  shift_q;
  logic [BcdW-1:0]   scratch_q;
  logic [CntW-1:0]   cnt_q;
  logic              ovf_pend_q;
  logic [BcdW-1:0]   bcd_q;
  logic              ovf_q;
  logic              busy_q;
  logic              done_q;

  logic [BcdW-1:0]   adj;
  logic              ovf_now;

  assign ovf_now = (32'(BIN) > MaxVal);

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adjust u_adj (
      .digit_i (scratch_q[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
      .digit_o (adj[g*BCD_DIGIT_W +: BCD_DIGIT_W])
    );
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q    <= StIdle;
      shift_q    <= '0;
      scratch_q  <= '0;
      cnt_q      <= '0;
      ovf_pend_q <= 1'b0;
      bcd_q      <= '0;
      ovf_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (START) begin
            shift_q    <= BIN;
            scratch_q  <= '0;
            cnt_q      <= CntW'(BIN_W - 1);
            ovf_pend_q <= ovf_now;
            busy_q     <= 1'b1;
            state_q    <= StShift;
          end
        end
        StShift: begin
          // Bits pushed past the top digit are lost; saturation covers that case.
          scratch_q <= {adj[BcdW-2:0], shift_q[BIN_W-1]};
          shift_q   <= {shift_q[BIN_W-2:0], 1'b0};
          cnt_q     <= cnt_q - CntW'(1);
          if (cnt_q == '0) begin
            state_q <= StDone;
          end
        end
        StDone: begin
          bcd_q   <= ovf_pend_q ? {DIGITS{4'h9}} : scratch_q;
          ovf_q   <= ovf_pend_q;
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign BUSY   = busy_q;
  assign DONE   = done_q;
  assign BCDOUT = bcd_q;
  assign OVF    = ovf_q;

endmodule
